dual_issue_decoder: RTL

- Decode stage of the superscalar CPU. Takes an RV32I instruction pair (lane A = older, lane B = younger) from fetch.
- Produces the enumerated control encodings consumed downstream: instruction type, ALU op, hazard code. Also produces register indices and the sign-extended immediate for each lane.
- Detects intra-pair RAW dependency and splits a dependent pair across two cycles.
- Sits between the fetch queue and the register-read/issue stage.

---
 rtl/dual_issue_decoder_pkg.sv | 36 +++
 rtl/rv32_lane_decode.sv | 129 ++++++++++++
 rtl/dual_issue_decoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dual_issue_decoder_pkg.sv
// Shared encodings for the dual-issue decode stage (optional DEC_ILLEGAL_FLAG_EN lives in the users).
package dual_issue_decoder_pkg;

    typedef enum logic [3:0] {
        ItR = 4'h0, ItImm = 4'h1, ItLoad = 4'h2, ItStore = 4'h3, ItBranch = 4'h4, ItJal = 4'h5,
        ItJalr = 4'h6, ItLui = 4'h7, ItAuipc = 4'h8, ItEcall = 4'h9, ItNop = 4'hA, ItNone = 4'hB
    } itype_e;

    typedef enum logic [4:0] {
        AluAdd  = 5'h00, AluSub  = 5'h01, AluXor  = 5'h02, AluOr   = 5'h03, AluAnd  = 5'h04,
        AluSll  = 5'h05, AluSrl  = 5'h06, AluSra  = 5'h07, AluSlt  = 5'h08, AluSltu = 5'h09,
        AluAddi = 5'h0A, AluXori = 5'h0B, AluOri  = 5'h0C, AluAndi = 5'h0D, AluSlli = 5'h0E,
        AluSrli = 5'h0F, AluSrai = 5'h11, AluSlti = 5'h12, AluSltiu = 5'h13,
        AluAddr = 5'h14, AluCmp  = 5'h15, AluNone = 5'h1F
    } aluop_e;

    typedef enum logic [3:0] {
        HazStallFromA = 4'h2,
        HazNone       = 4'h9
    } haz_e;

    localparam logic [6:0] OpcReg    = 7'h33;
    localparam logic [6:0] OpcImm    = 7'h13;
    localparam logic [6:0] OpcLoad   = 7'h03;
    localparam logic [6:0] OpcStore  = 7'h23;
    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcJal    = 7'h6F;
    localparam logic [6:0] OpcJalr   = 7'h67;
    localparam logic [6:0] OpcLui    = 7'h37;
    localparam logic [6:0] OpcAuipc  = 7'h17;
    localparam logic [6:0] OpcSystem = 7'h73;

    localparam logic [31:0] NopInstr   = 32'h0000_0013;
    localparam logic [31:0] EcallInstr = 32'h0000_0073;

endpackage

// File: rtl/rv32_lane_decode.sv
// Combinational RV32I single-instruction decode; illegal port exists only with DEC_ILLEGAL_FLAG_EN.
module rv32_lane_decode
    import dual_issue_decoder_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [XLEN-1:0]   instr,
    output itype_e            itype,
    output aluop_e            aluop,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [XLEN-1:0]   imm
`ifdef DEC_ILLEGAL_FLAG_EN
    ,
    output logic              illegal
`endif
);

    logic [31:0] ins;
    logic [31:0] imm32;
    logic [9:0]  fn;
    logic        use_rd, use_rs1, use_rs2;

    assign ins = ins_w(instr);
    assign fn  = {ins[31:25], ins[14:12]};

    function automatic logic [31:0] ins_w(input logic [XLEN-1:0] v);
        return v[31:0];
    endfunction

    always_comb begin
        itype   = ItNone;
        aluop   = AluNone;
        imm32   = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (ins[6:0])
            OpcReg: begin
                {itype, use_rd, use_rs1, use_rs2} = {ItR, 3'b111};
                case (fn)
                    {7'h00, 3'd0}: aluop = AluAdd;
                    {7'h20, 3'd0}: aluop = AluSub;
                    {7'h00, 3'd1}: aluop = AluSll;
                    {7'h00, 3'd2}: aluop = AluSlt;
                    {7'h00, 3'd3}: aluop = AluSltu;
                    {7'h00, 3'd4}: aluop = AluXor;
                    {7'h00, 3'd5}: aluop = AluSrl;
                    {7'h20, 3'd5}: aluop = AluSra;
                    {7'h00, 3'd6}: aluop = AluOr;
                    {7'h00, 3'd7}: aluop = AluAnd;
                    default:       itype = ItNone;
                endcase
            end
            OpcImm: begin
                if (ins == NopInstr) begin
                    itype = ItNop;
                end else begin
                    {itype, use_rd, use_rs1} = {ItImm, 2'b11};
                    imm32 = {{20{ins[31]}}, ins[31:20]};
                    case (ins[14:12])
                        3'd0: aluop = AluAddi;
                        3'd2: aluop = AluSlti;
                        3'd3: aluop = AluSltiu;
                        3'd4: aluop = AluXori;
                        3'd6: aluop = AluOri;
                        3'd7: aluop = AluAndi;
                        3'd1: if (ins[31:25] == 7'h00) aluop = AluSlli; else itype = ItNone;
                        default: begin
                            if (ins[31:25] == 7'h00)      aluop = AluSrli;
                            else if (ins[31:25] == 7'h20) aluop = AluSrai;
                            else                          itype = ItNone;
                        end
                    endcase
                end
            end
            OpcLoad: begin
                {itype, aluop, use_rd, use_rs1} = {ItLoad, AluAddr, 2'b11};
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            OpcStore: begin
                {itype, aluop, use_rs1, use_rs2} = {ItStore, AluAddr, 2'b11};
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OpcBranch: begin
                {itype, aluop, use_rs1, use_rs2} = {ItBranch, AluCmp, 2'b11};
                imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OpcJal: begin
                {itype, use_rd} = {ItJal, 1'b1};
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OpcJalr: begin
                {itype, aluop, use_rd, use_rs1} = {ItJalr, AluAddr, 2'b11};
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            OpcLui: begin
                {itype, use_rd} = {ItLui, 1'b1};
                imm32 = {ins[31:12], 12'h000};
            end
            OpcAuipc: begin
                {itype, aluop, use_rd} = {ItAuipc, AluAddr, 1'b1};
                imm32 = {ins[31:12], 12'h000};
            end
            OpcSystem: if (ins == EcallInstr) itype = ItEcall;
            default: itype = ItNone;
        endcase
        // Anything undecodable carries no operands so it can never create a dependency.
        if (itype == ItNone) begin
            aluop   = AluNone;
            imm32   = '0;
            use_rd  = 1'b0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    assign rd  = use_rd  ? REG_AW'(ins[11:7])  : '0;
    assign rs1 = use_rs1 ? REG_AW'(ins[19:15]) : '0;
    assign rs2 = use_rs2 ? REG_AW'(ins[24:20]) : '0;
    assign imm = XLEN'($signed(imm32));

`ifdef DEC_ILLEGAL_FLAG_EN
    assign illegal = (itype == ItNone);
`endif

endmodule

// File: rtl/dual_issue_decoder.sv
// Dual-issue RV32I decode stage with intra-pair RAW split; DEC_ILLEGAL_FLAG_EN adds illegal_a/b.
module dual_issue_decoder
    import dual_issue_decoder_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   instr_a,
    input  logic [XLEN-1:0]   instr_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              valid_a,
    output logic              valid_b,
    output logic [3:0]        itype_a,
    output logic [3:0]        itype_b,
    output logic [4:0]        aluop_a,
    output logic [4:0]        aluop_b,
    output logic [3:0]        haz_b,
    output logic [REG_AW-1:0] rd_a,
    output logic [REG_AW-1:0] rs1_a,
    output logic [REG_AW-1:0] rs2_a,
    output logic [REG_AW-1:0] rd_b,
    output logic [REG_AW-1:0] rs1_b,
    output logic [REG_AW-1:0] rs2_b,
    output logic [XLEN-1:0]   imm_a,
    output logic [XLEN-1:0]   imm_b
`ifdef DEC_ILLEGAL_FLAG_EN
    ,
    output logic              illegal_a,
    output logic              illegal_b
`endif
);

    typedef struct packed {
        itype_e            itype;
        aluop_e            aluop;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [XLEN-1:0]   imm;
`ifdef DEC_ILLEGAL_FLAG_EN
        logic              illegal;
`endif
    } lane_t;

    typedef enum logic [0:0] {StPair, StSplit} state_e;

    state_e state_q;
    lane_t  dec_a, dec_b, lane_a_q, lane_b_q, lane_rst;
    logic   out_valid_q, valid_a_q, valid_b_q;
    haz_e   haz_b_q;
    logic   advance, accept, dep;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        lane_t dec;
        rv32_lane_decode #(.XLEN(XLEN), .REG_AW(REG_AW)) u_dec (
            .instr   (g == 0 ? instr_a : instr_b),
            .itype   (dec.itype),
            .aluop   (dec.aluop),
            .rd      (dec.rd),
            .rs1     (dec.rs1),
            .rs2     (dec.rs2),
            .imm     (dec.imm)
`ifdef DEC_ILLEGAL_FLAG_EN
            ,
            .illegal (dec.illegal)
`endif
        );
    end
    assign dec_a = g_lane[0].dec;
    assign dec_b = g_lane[1].dec;

    always_comb begin
        lane_rst       = '0;
        lane_rst.itype = ItNone;
        lane_rst.aluop = AluNone;
    end

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = (state_q == StPair) && advance;
    assign accept   = in_valid && in_ready;
    // Indices are zeroed when unused, so a plain compare only hits real writes and reads.
    assign dep = (dec_a.rd != '0) && ((dec_a.rd == dec_b.rs1) || (dec_a.rd == dec_b.rs2));

    // Lane B's register doubles as the held copy while split.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q     <= StPair;
            out_valid_q <= 1'b0;
            valid_a_q   <= 1'b0;
            valid_b_q   <= 1'b0;
            haz_b_q     <= HazNone;
            lane_a_q    <= lane_rst;
            lane_b_q    <= lane_rst;
        end else begin
            unique case (state_q)
                StPair: begin
                    if (accept) begin
                        out_valid_q <= 1'b1;
                        valid_a_q   <= 1'b1;
                        valid_b_q   <= !dep;
                        haz_b_q     <= dep ? HazStallFromA : HazNone;
                        state_q     <= dep ? StSplit : StPair;
                        lane_a_q    <= dec_a;
                        lane_b_q    <= dec_b;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        valid_a_q   <= 1'b0;
                        valid_b_q   <= 1'b0;
                    end
                end
                StSplit: begin
                    if (advance) begin
                        out_valid_q <= 1'b1;
                        valid_a_q   <= 1'b0;
                        valid_b_q   <= 1'b1;
                        haz_b_q     <= HazNone;
                        state_q     <= StPair;
                    end
                end
                default: state_q <= StPair;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign valid_a   = valid_a_q;
    assign valid_b   = valid_b_q;
    assign haz_b     = haz_b_q;
    assign itype_a   = lane_a_q.itype;
    assign itype_b   = lane_b_q.itype;
    assign aluop_a   = lane_a_q.aluop;
    assign aluop_b   = lane_b_q.aluop;
    assign rd_a      = lane_a_q.rd;
    assign rs1_a     = lane_a_q.rs1;
    assign rs2_a     = lane_a_q.rs2;
    assign rd_b      = lane_b_q.rd;
    assign rs1_b     = lane_b_q.rs1;
    assign rs2_b     = lane_b_q.rs2;
    assign imm_a     = lane_a_q.imm;
    assign imm_b     = lane_b_q.imm;
`ifdef DEC_ILLEGAL_FLAG_EN
    assign illegal_a = lane_a_q.illegal;
    assign illegal_b = lane_b_q.illegal;
`endif

endmodule
